// File: rtl/ntt_last_stage_pipe.sv
// Final-layer Kyber NTT/INTT butterfly stage with self-generated twiddle addresses.
// NTT: Cooley-Tukey butterfly. INTT: Gentleman-Sande butterfly, then both outputs
// scaled by NINV. Four stages in both modes, so output alignment is mode independent.
// The twiddle ROM is expected to share the en clock-enable, so tw_data holds during stalls.
module ntt_last_stage_pipe #(
  parameter int unsigned W            = 12,
  parameter int unsigned Q            = 3329,
  parameter int unsigned NINV         = 3303,
  parameter int unsigned AW           = 7,
  parameter int unsigned TW_BASE      = 64,
  parameter int unsigned TW_CNT       = 64,
  parameter int unsigned PAIRS_PER_TW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          clr,
  input  logic          mode,
  input  logic          in_valid,
  input  logic [W-1:0]  i1,
  input  logic [W-1:0]  i2,
  output logic [AW-1:0] tw_addr,
  input  logic [W-1:0]  tw_data,
  output logic          out_valid,
  output logic [W-1:0]  o1,
  output logic [W-1:0]  o2
);

  localparam logic [AW-1:0] AddrLo = AW'(TW_BASE);
  localparam logic [AW-1:0] AddrHi = AW'(TW_BASE + TW_CNT - 1);
  localparam int unsigned   CW     = (PAIRS_PER_TW > 1) ? $clog2(PAIRS_PER_TW) : 1;
  localparam logic [CW-1:0] CntLast = CW'(PAIRS_PER_TW - 1);

  function automatic logic [W-1:0] mod_add(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= (W+1)'(Q)) s = s - (W+1)'(Q);
    return s[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_sub(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (x < y) d = d + (W+1)'(Q);
    return d[W-1:0];
  endfunction

  function automatic logic [W-1:0] mod_mul(input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, x} * {{W{1'b0}}, y};
    return W'(p % (2*W)'(Q));
  endfunction

  // Address generation state
  logic [AW-1:0] addr_q, addr_d, start_addr, cur_addr, next_addr;
  logic [CW-1:0] cnt_q, cnt_d, cur_cnt;
  logic          last_mode_q, last_mode_d;
  logic          accept, seq_start;

  // Pipeline state
  logic          v1_q, m1_q, v2_q, m2_q, v3_q, m3_q;
  logic [W-1:0]  a1_q, b1_q, x2_q, y2_q, w2_q, x3_q, y3_q;
  logic [W-1:0]  x2_d, y2_d, x3_d, y3_d, o1_d, o2_d;

  // Next twiddle address / pair counter; a mode change restarts the sequence on the
  // very pair that carries it, so the start address is muxed onto tw_addr that cycle.
  always_comb begin
    start_addr  = mode ? AddrHi : AddrLo;
    accept      = en & in_valid & ~clr;
    seq_start   = accept & (mode != last_mode_q);
    cur_addr    = seq_start ? start_addr : addr_q;
    cur_cnt     = seq_start ? '0 : cnt_q;
    if (mode) next_addr = (cur_addr == AddrLo) ? AddrHi : cur_addr - AW'(1);
    else      next_addr = (cur_addr == AddrHi) ? AddrLo : cur_addr + AW'(1);
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    last_mode_d = last_mode_q;
    if (clr) begin
      addr_d      = start_addr;
      cnt_d       = '0;
      last_mode_d = mode;
    end else if (accept) begin
      last_mode_d = mode;
      if (cur_cnt == CntLast) begin
        cnt_d  = '0;
        addr_d = next_addr;
      end else begin
        cnt_d  = cur_cnt + CW'(1);
        addr_d = cur_addr;
      end
    end
  end

  assign tw_addr = cur_addr;

  // Butterfly datapath per stage; mode travels with the data
  always_comb begin
    x2_d = m1_q ? mod_add(a1_q, b1_q) : a1_q;
    y2_d = m1_q ? mod_sub(a1_q, b1_q) : mod_mul(b1_q, tw_data);
    x3_d = m2_q ? x2_q : mod_add(x2_q, y2_q);
    y3_d = m2_q ? mod_mul(y2_q, w2_q) : mod_sub(x2_q, y2_q);
    o1_d = m3_q ? mod_mul(x3_q, W'(NINV)) : x3_q;
    o2_d = m3_q ? mod_mul(y3_q, W'(NINV)) : y3_q;
  end

  // Address generator registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q      <= AddrLo;
      cnt_q       <= '0;
      last_mode_q <= 1'b0;
    end else if (en) begin
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      last_mode_q <= last_mode_d;
    end
  end

  // Pipeline registers; clr only drops valid bits, outputs hold when no result arrives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q <= 1'b0; m1_q <= 1'b0; a1_q <= '0; b1_q <= '0;
      v2_q <= 1'b0; m2_q <= 1'b0; x2_q <= '0; y2_q <= '0; w2_q <= '0;
      v3_q <= 1'b0; m3_q <= 1'b0; x3_q <= '0; y3_q <= '0;
      out_valid <= 1'b0; o1 <= '0; o2 <= '0;
    end else if (en) begin
      m1_q <= mode; a1_q <= i1; b1_q <= i2;
      m2_q <= m1_q; x2_q <= x2_d; y2_q <= y2_d; w2_q <= tw_data;
      m3_q <= m2_q; x3_q <= x3_d; y3_q <= y3_d;
      if (v3_q && !clr) begin
        o1 <= o1_d;
        o2 <= o2_d;
      end
      if (clr) begin
        v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; out_valid <= 1'b0;
      end else begin
        v1_q <= in_valid; v2_q <= v1_q; v3_q <= v2_q; out_valid <= v3_q;
      end
    end
  end

endmodule
